os_context_ctrl: RTL

//  Parametrised OS environment/context controller for the YouseiOS core. Decodes
//  OS opcodes (instr[31:26]) to hold the current PID and run a round-robin quantum

---
 rtl/os_context_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/os_context_ctrl.sv
// OS context controller: current PID, round-robin quantum timer, next-PID picker,
// message FIFO and page/memory strobes, all decoded from instr[31:26].
module os_context_ctrl #(
  parameter int unsigned PID_W     = 5,
  parameter int unsigned NUM_PROC  = 4,
  parameter int unsigned QUANTUM   = 16,
  parameter int unsigned MSG_W     = 5,
  parameter int unsigned MSG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                instr,
  input  logic                       instr_valid,
  input  logic                       save_page,
  input  logic [NUM_PROC-1:0]        proc_active,
  output logic [PID_W-1:0]           pid_out,
  output logic [PID_W-1:0]           next_pid,
  output logic                       so_kernel,
  output logic [$clog2(QUANTUM)-1:0] quantum_left,
  output logic [MSG_W-1:0]           msg_data,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic                       msg_overflow,
  output logic                       page_update,
  output logic                       mem_write
);

  localparam int unsigned QW = $clog2(QUANTUM);
  localparam int unsigned AW = $clog2(MSG_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [5:0] OP_EMIT_MSG    = 6'b011010;
  localparam logic [5:0] OP_ROUND_ROBIN = 6'b011011;
  localparam logic [5:0] OP_SET_PID     = 6'b011100;
  localparam logic [5:0] OP_CREATE_FILE = 6'b011101;
  localparam logic [5:0] OP_KERNEL_SWAP = 6'b100001;
  localparam logic [5:0] OP_INPUT       = 6'b001000;
  localparam logic [5:0] OP_HD_READ     = 6'b011111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PID_W-1:0]     pid_q, pid_d;
  logic [QW-1:0]        ql_q, ql_d;
  logic                 so_kernel_q, so_kernel_d;
  logic                 mem_write_q, mem_write_d;
  logic                 overflow_q, overflow_d;
  logic [MSG_W-1:0]     mem_q [MSG_DEPTH];
  logic [MSG_W-1:0]     mem_d [MSG_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [5:0] opcode;
  logic       op_emit, op_rr, op_set, op_create, op_ks, op_input, op_hd;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign op_emit      = instr_valid && (opcode == OP_EMIT_MSG);
  assign op_rr        = instr_valid && (opcode == OP_ROUND_ROBIN);
  assign op_set       = instr_valid && (opcode == OP_SET_PID);
  assign op_create    = instr_valid && (opcode == OP_CREATE_FILE);
  assign op_ks        = instr_valid && (opcode == OP_KERNEL_SWAP);
  assign op_input     = instr_valid && (opcode == OP_INPUT);
  assign op_hd        = instr_valid && (opcode == OP_HD_READ);
  assign unused_instr = ^instr;

  // Round-robin pick: start at the slot after the current PID, wrap around.
  always_comb begin
    int unsigned         start;
    int unsigned         idx;
    logic                found;
    logic [NUM_PROC-1:0] sh;
    next_pid = '0;
    found    = 1'b0;
    idx      = 0;
    sh       = '0;
    if (pid_q != '0 && 32'(pid_q) <= NUM_PROC) start = 32'(pid_q) % NUM_PROC;
    else                                        start = 0;
    for (int unsigned off = 0; off < NUM_PROC; off++) begin
      idx = start + off;
      if (idx >= NUM_PROC) idx = idx - NUM_PROC;
      sh = proc_active >> idx;
      if (!found && sh[0]) begin
        found    = 1'b1;
        next_pid = PID_W'(idx + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ql_d    = ql_q;
    pid_d   = pid_q;
    if (op_set) pid_d = instr[PID_W-1:0];
    unique case (state_q)
      IDLE: begin
        if (op_rr) begin
          state_d = RUN;
          ql_d    = QW'(QUANTUM - 1);
        end
      end
      RUN: begin
        if (op_ks) begin
          state_d = IDLE;
          ql_d    = '0;
        end else if (op_rr) begin
          ql_d = QW'(QUANTUM - 1);
        end else if (!op_input) begin
          if (ql_q == QW'(1)) begin
            state_d = EXPIRED;
            ql_d    = '0;
          end else begin
            ql_d = ql_q - QW'(1);
          end
        end
      end
      EXPIRED: begin
        if (op_ks) begin
          state_d = IDLE;
          pid_d   = next_pid;
        end
      end
      default: begin
        state_d = IDLE;
        ql_d    = '0;
      end
    endcase
    so_kernel_d = (state_d == EXPIRED);
    mem_write_d = op_hd;
  end

  // When full, a push is accepted only if the head leaves on the same edge.
  always_comb begin
    logic full, do_pop, do_push;
    full       = (count_q == CW'(MSG_DEPTH));
    do_pop     = (count_q != '0) && msg_ready;
    do_push    = op_emit && (!full || do_pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = instr[MSG_W-1:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
    if (op_emit && full && !do_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pid_q       <= '0;
      ql_q        <= '0;
      so_kernel_q <= 1'b0;
      mem_write_q <= 1'b0;
      overflow_q  <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      ql_q        <= ql_d;
      so_kernel_q <= so_kernel_d;
      mem_write_q <= mem_write_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign pid_out      = pid_q;
  assign so_kernel    = so_kernel_q;
  assign quantum_left = ql_q;
  assign msg_valid    = (count_q != '0);
  assign msg_data     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign msg_overflow = overflow_q;
  assign mem_write    = mem_write_q;
  assign page_update  = save_page || op_create;

endmodule
